rotator_arbiter: RTL and testbench

- Shares one W-bit barrel rotator datapath among NREQ requesters.
- Each requester presents data, a rotate amount and a direction under a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle. The rotated result is registered into a single-entry output stage with valid/ready backpressure.
- Sits between several producer blocks and a downstream consumer, so the rotator does not have to be replicated per producer.

---
 rtl/rot_pkg.sv | 16 +
 rtl/rotator_arbiter_if.sv | 36 +++
 rtl/rot_core.sv | 27 ++
 rtl/rotator_arbiter.sv | 94 +++++++++
 tb/tb_rotator_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rot_pkg.sv
// Shared constants and helpers for the rotator arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rot_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int ROT_W = 4;

  // Round-robin successor of idx among n slots, wrapping n-1 -> 0.
  function automatic int next_rr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rotator_arbiter_if.sv
// Request/result bundle between producers, the rotator arbiter and the consumer.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates producers, out_ready gates the result stage.
interface rotator_arbiter_if
  import rot_pkg::*;
#(
  parameter int W    = ROT_W,
  parameter int NREQ = 4
);

  localparam int AMT_W = $clog2(W);
  localparam int ID_W  = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*W-1:0]     req_data;
  logic [NREQ*AMT_W-1:0] req_amt;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [W-1:0]          out_data;
  logic [ID_W-1:0]       out_id;
  logic                  out_ready;

  // Producer/consumer side of the bundle.
  modport master (
    output req_valid, req_data, req_amt, req_dir, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  // Arbiter side of the bundle.
  modport slave (
    input  req_valid, req_data, req_amt, req_dir, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/rot_core.sv
// Combinational W-bit barrel rotator, left or right by amt.
// Latency: 0 cycles (pure logic).
// Backpressure: none; the caller registers the result.
module rot_core
  import rot_pkg::*;
#(
  parameter int W = ROT_W
) (
  input  logic [W-1:0]         data_in,
  input  logic [$clog2(W)-1:0] amt,
  input  logic                 dir,
  output logic [W-1:0]         data_out
);

  logic [2*W-1:0] dbl;
  logic [2*W-1:0] shl;
  logic [2*W-1:0] shr;

  // Doubling the word turns a rotate into a plain shift plus a window select.
  assign dbl = {data_in, data_in};
  assign shl = dbl << amt;
  assign shr = dbl >> amt;

  // Left takes the upper window of the left shift, right the lower window.
  assign data_out = (dir == DIR_RIGHT) ? shr[W-1:0] : shl[2*W-1:W];

endmodule

// File: rtl/rotator_arbiter.sv
// Round-robin shares one barrel rotator among NREQ requesters; result in a 1-entry register.
// Latency: 1 cycle from request handshake to out_valid; one result per cycle sustained.
// Backpressure: a held result with out_ready low drops every req_ready; reload same cycle on drain.
module rotator_arbiter
  import rot_pkg::*;
#(
  parameter int W    = ROT_W,
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  rotator_arbiter_if.slave   bus
);

  localparam int AMT_W = $clog2(W);
  localparam int ID_W  = $clog2(NREQ);

  logic [ID_W-1:0]  rr_ptr;
  logic             out_valid_r;
  logic [W-1:0]     out_data_r;
  logic [ID_W-1:0]  out_id_r;

  logic             accept;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [NREQ-1:0]  grant;
  logic [W-1:0]     win_data;
  logic [AMT_W-1:0] win_amt;
  logic             win_dir;
  logic [W-1:0]     rot_data;

  // The output register can take a new result when empty or being drained now.
  assign accept = !out_valid_r || bus.out_ready;

  // First valid requester at or after rr_ptr, wrapping around, wins.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Only the winner sees ready, and only when the result slot can take it.
  always_comb begin
    grant = '0;
    if (!rst && accept && found) grant[winner] = 1'b1;
  end

  assign bus.req_ready = grant;

  // Steer the winner's fields into the single shared rotator.
  assign win_data = bus.req_data[int'(winner)*W +: W];
  assign win_amt  = bus.req_amt[int'(winner)*AMT_W +: AMT_W];
  assign win_dir  = bus.req_dir[winner];

  rot_core #(.W(W)) u_rot (
    .data_in  (win_data),
    .amt      (win_amt),
    .dir      (win_dir),
    .data_out (rot_data)
  );

  // Result stage: load on grant, clear valid on drain, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      if (found) begin
        out_valid_r <= 1'b1;
        out_data_r  <= rot_data;
        out_id_r    <= winner;
        rr_ptr      <= ID_W'(next_rr(int'(winner), NREQ));
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_id    = out_id_r;

endmodule

// File: tb/tb_rotator_arbiter.sv
// Randomized plus directed bench for rotator_arbiter against a behavioural model.
// Latency: model predicts the registered result one cycle after each grant.
// Backpressure: out_ready is driven randomly and held low in directed stalls.
module tb_rotator_arbiter;
  import rot_pkg::*;

  localparam int W     = 4;
  localparam int NREQ  = 4;
  localparam int AMT_W = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rotator_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

  rotator_arbiter #(.W(W), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Per-requester stimulus state; a requester holds its fields until served.
  logic             rv   [NREQ];
  logic [W-1:0]     rd   [NREQ];
  logic [AMT_W-1:0] ra   [NREQ];
  logic             rdir [NREQ];
  logic             out_rdy;

  // Behavioural model of the output stage and fairness pointer.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  int           m_ptr;
  logic [NREQ-1:0] seen_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Rotation straight from the index definition: left out[k]=in[k-a], right out[k]=in[k+a].
  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d, input int a, input logic right);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++)
      r[k] = right ? d[(k + a) % W] : d[(k - a + W) % W];
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]              = rv[i];
      bus.req_data[i*W +: W]        = rd[i];
      bus.req_amt[i*AMT_W +: AMT_W] = ra[i];
      bus.req_dir[i]                = rdir[i];
    end
    bus.out_ready = out_rdy;
  endtask

  // One clock: check DUT against model, then advance the model across the edge.
  task automatic step();
    int g;
    int idx;
    logic acc;
    logic [NREQ-1:0] exp_rdy;
    drive();
    #1;
    acc = !m_valid || out_rdy;
    g = -1;
    for (int off = 0; off < NREQ; off++) begin
      idx = (m_ptr + off) % NREQ;
      if (g < 0 && rv[idx]) g = idx;
    end
    exp_rdy = '0;
    if (!rst && acc && g >= 0) exp_rdy[g] = 1'b1;
    seen_rdy = bus.req_ready;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
    chk("out_id",    32'(bus.out_id),    m_id);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
    end else if (acc) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = ref_rot(rd[g], int'(ra[g]), rdir[g]);
        m_id    = g;
        m_ptr   = (g + 1) % NREQ;
        rv[g]   = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic post(input int i, input logic [W-1:0] d, input int a, input logic dr);
    rv[i]   = 1'b1;
    rd[i]   = d;
    ra[i]   = AMT_W'(a);
    rdir[i] = dr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  int sk_exp[4] = '{1, 3, 1, 3};
  int rdy_hits[NREQ];

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0; rd[i] = '0; ra[i] = '0; rdir[i] = 1'b0;
    end
    out_rdy = 1'b1;
    m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
    rst = 1'b1;
    post(0, 4'b1010, 1, DIR_LEFT);
    drive();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    step();
    chk("rst_ready", 32'(seen_rdy), 32'd0);
    rst = 1'b0;
    rv[0] = 1'b0;

    // Basic rotations of 1001 by requester 0.
    post(0, 4'b1001, 1, DIR_LEFT);  step(); chk("rot_l1", 32'(bus.out_data), 32'(4'b0011));
    chk("rot_l1_id", 32'(bus.out_id), 32'd0);
    post(0, 4'b1001, 1, DIR_RIGHT); step(); chk("rot_r1", 32'(bus.out_data), 32'(4'b1100));
    post(0, 4'b1001, 2, DIR_LEFT);  step(); chk("rot_l2", 32'(bus.out_data), 32'(4'b0110));
    post(0, 4'b1001, 2, DIR_RIGHT); step(); chk("rot_r2", 32'(bus.out_data), 32'(4'b0110));
    post(0, 4'b1001, 0, DIR_RIGHT); step(); chk("rot_0",  32'(bus.out_data), 32'(4'b1001));

    // Drain: single request, valid high for exactly one cycle.
    step(); chk("drain_a", 32'(bus.out_valid), 32'd0);
    post(2, 4'b0001, 3, DIR_LEFT); step(); chk("drain_b", 32'(bus.out_valid), 32'd1);
    step(); chk("drain_c", 32'(bus.out_valid), 32'd0);
    chk("drain_hold", 32'(bus.out_data), 32'(4'b1000));

    // Round robin with all requesters continuously valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) rdy_hits[i] = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) post(i, W'(i + 5), i % W, 1'(i));
      step();
      if (k < 4) for (int i = 0; i < NREQ; i++) rdy_hits[i] += int'(seen_rdy[i]);
      chk("rr_id", 32'(bus.out_id), rr_exp[k]);
    end
    for (int i = 0; i < NREQ; i++) chk("rr_fair", rdy_hits[i], 1);
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;

    // Pointer skip over idle indices.
    do_reset();
    step();
    for (int k = 0; k < 4; k++) begin
      post(1, 4'b0110, 1, DIR_LEFT);
      post(3, 4'b1110, 1, DIR_RIGHT);
      step();
      chk("skip_id", 32'(bus.out_id), sk_exp[k]);
      chk("skip_v", 32'(bus.out_valid), 32'd1);
    end
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;

    // Backpressure: stall three cycles, then reload in the release cycle.
    do_reset();
    post(0, 4'b1001, 1, DIR_LEFT);
    step();
    out_rdy = 1'b0;
    post(2, 4'b0101, 1, DIR_LEFT);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_ready", 32'(seen_rdy), 32'd0);
      chk("bp_data", 32'(bus.out_data), 32'(4'b0011));
      chk("bp_id", 32'(bus.out_id), 32'd0);
    end
    out_rdy = 1'b1;
    step();
    chk("bp_release_rdy", 32'(seen_rdy), 32'(4'b0100));
    chk("bp_release_id", 32'(bus.out_id), 32'd2);
    chk("bp_release_data", 32'(bus.out_data), 32'(4'b1010));

    // Reset while a result is stalled.
    out_rdy = 1'b0;
    post(1, 4'b0111, 2, DIR_LEFT);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_ready", 32'(seen_rdy), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) post(i, W'(i), 0, DIR_LEFT);
    step();
    chk("mid_rst_restart", 32'(bus.out_id), 32'd0);

    // Random traffic with random backpressure and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rv[i] && $urandom_range(0, 2) == 0)
          post(i, W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom));
      out_rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
